// File: rtl/fifo_multi.sv
// fifo_multi: multi-lane circular FIFO with head checkpoint/restore, usable as a free list or an instruction queue
package fifo_multi_pkg;
    typedef enum logic {DEFAULT, FREE_LIST} fifo_custom_t;
endpackage

module fifo_multi
    import fifo_multi_pkg::*;
#(
    parameter int           WIDTH = 32,
    parameter int           DEPTH = 32,
    parameter int           ENQ_W = 2,
    parameter int           DEQ_W = 2,
    parameter fifo_custom_t INIT  = DEFAULT,
    localparam int          AW    = $clog2(DEPTH),
    localparam int          EW    = $clog2(ENQ_W + 1),
    localparam int          DW    = $clog2(DEQ_W + 1),
    localparam int          PW    = AW + 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [EW-1:0]          enq_cnt,
    input  logic [ENQ_W*WIDTH-1:0] enq_data,
    output logic                   enq_ready,
    input  logic [DW-1:0]          deq_cnt,
    output logic [DEQ_W*WIDTH-1:0] deq_data,
    output logic [DEQ_W-1:0]       deq_valid,
    output logic [PW-1:0]          count,
    output logic                   near_empty,
    output logic [PW-1:0]          head_ptr,
    input  logic                   restore_req,
    input  logic [PW-1:0]          restore_ptr
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head, r_tail;
    logic [PW-1:0]    w_count, w_pop, w_enq_n, w_span;

    assign w_count    = r_tail - r_head;
    assign enq_ready  = w_count <= PW'(DEPTH - ENQ_W);
    assign w_enq_n    = enq_ready ? PW'(enq_cnt) : '0;
    assign w_pop      = (PW'(deq_cnt) > w_count) ? w_count : PW'(deq_cnt);
    assign w_span     = r_tail + w_enq_n - restore_ptr;
    assign count      = w_count;
    assign near_empty = w_count < PW'(DEQ_W);
    assign head_ptr   = r_head;

    // Pointer update: reset/flush restore the initial fill, restore overrides only the head
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head <= '0;
            r_tail <= (INIT == FREE_LIST) ? PW'(DEPTH) : '0;
        end else begin
            r_head <= restore_req ? restore_ptr : r_head + w_pop;
            r_tail <= r_tail + w_enq_n;
        end
    end

    // Storage: free list preloads identity tags; accepted lanes land at consecutive tail slots
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            if (INIT == FREE_LIST)
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= WIDTH'(i);
        end else if (enq_ready) begin
            for (int i = 0; i < ENQ_W; i++)
                if (EW'(i) < enq_cnt) r_mem[AW'(r_tail[AW-1:0] + AW'(i))] <= enq_data[i*WIDTH +: WIDTH];
        end
    end

    // Zero-latency read lanes starting at the head, with per-lane occupancy
    always_comb begin
        deq_data  = '0;
        deq_valid = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            deq_valid[j]               = w_count > PW'(j);
            deq_data[j*WIDTH +: WIDTH] = r_mem[AW'(r_head[AW-1:0] + AW'(j))];
        end
    end

    // Flag illegal usage: bad lane counts, overfill, or a restore point too far behind the tail
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ((DEPTH & (DEPTH - 1)) == 0);
            assert (enq_cnt <= EW'(ENQ_W));
            assert (deq_cnt <= DW'(DEQ_W));
            assert (w_count <= PW'(DEPTH));
            if (!flush && restore_req) assert (w_span <= PW'(DEPTH));
        end
    end
endmodule
